// File: rtl/allocate_sysreg_commit_buffer.sv
// ---------------------------------------------------------------------------
// allocate_sysreg_commit_buffer
// In-order staging buffer for speculative system-register writes. Writes are
// queued at allocate, released one per retire as a one-cycle one-hot strobe
// plus data towards the per-register holders, and discarded on flush.
//
// Ports:
//   iCLOCK, iRESET (async, active-high), iRESET_SYNC (sync clear)
//   iWR_VALID/iWR_ADDR/iWR_DATA  enqueue a speculative write; oWR_BUSY = full
//   iCOMMIT_VALID                retire oldest entry
//   iFLUSH                       drop all uncommitted entries
//   oREGIST_DATA_VALID/oREGIST_DATA  strobe + data to the register holders
//   oEMPTY, oCOUNT               occupancy status
// Optional (macro ALLOCATE_SYSREG_FORWARD_EN):
//   iLOOKUP_ADDR, oLOOKUP_HIT, oLOOKUP_DATA  youngest-match forwarding lookup
// ---------------------------------------------------------------------------
module allocate_sysreg_commit_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NUM_REG = 8,
    parameter int unsigned ADDR_W  = 5
) (
    input  logic                        iCLOCK,
    input  logic                        iRESET,
    input  logic                        iRESET_SYNC,
    input  logic                        iWR_VALID,
    input  logic [ADDR_W-1:0]           iWR_ADDR,
    input  logic [31:0]                 iWR_DATA,
    output logic                        oWR_BUSY,
    input  logic                        iCOMMIT_VALID,
    input  logic                        iFLUSH,
    output logic [NUM_REG-1:0]          oREGIST_DATA_VALID,
    output logic [31:0]                 oREGIST_DATA,
    output logic                        oEMPTY,
`ifdef ALLOCATE_SYSREG_FORWARD_EN
    input  logic [ADDR_W-1:0]           iLOOKUP_ADDR,
    output logic                        oLOOKUP_HIT,
    output logic [31:0]                 oLOOKUP_DATA,
`endif
    output logic [$clog2(DEPTH):0]      oCOUNT
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [ADDR_W-1:0]  r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [NUM_REG-1:0] r_strobe;
    logic [31:0]        r_regist_data;

    logic [IDX_W-1:0]   w_rd_idx;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [PTR_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [31:0]        w_head_data;
    logic               w_head_in_range;
    logic [PTR_W-1:0]   w_rptr_nxt;
    logic [PTR_W-1:0]   w_wptr_nxt;

    // Occupancy derived from registered pointers only
    assign w_rd_idx = r_rptr[IDX_W-1:0];
    assign w_wr_idx = r_wptr[IDX_W-1:0];
    assign w_count  = r_wptr - r_rptr;
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (w_rd_idx == w_wr_idx) && (r_wptr[IDX_W] != r_rptr[IDX_W]);

    assign w_head_addr     = r_addr[w_rd_idx];
    assign w_head_data     = r_data[w_rd_idx];
    assign w_head_in_range = (32'(w_head_addr) < NUM_REG);

    // A flush in the same cycle suppresses any enqueue
    assign w_pop  = iCOMMIT_VALID && !w_empty;
    assign w_push = iWR_VALID && !w_full && !iFLUSH;

    // Flush collapses the write pointer onto the post-commit read pointer
    always_comb begin
        w_rptr_nxt = r_rptr + PTR_W'(w_pop);
        w_wptr_nxt = r_wptr + PTR_W'(w_push);
        if (iFLUSH) begin
            w_wptr_nxt = w_rptr_nxt;
        end
    end

    // Pointer and commit-output state
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_strobe      <= '0;
            r_regist_data <= '0;
        end else if (iRESET_SYNC) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_strobe      <= '0;
            r_regist_data <= '0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_strobe <= '0;
            if (w_pop && w_head_in_range) begin
                r_strobe      <= NUM_REG'(1) << w_head_addr;
                r_regist_data <= w_head_data;
            end
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge iCLOCK) begin
        if (w_push && !iRESET_SYNC) begin
            r_addr[w_wr_idx] <= iWR_ADDR;
            r_data[w_wr_idx] <= iWR_DATA;
        end
    end

`ifdef ALLOCATE_SYSREG_FORWARD_EN
    logic        w_lookup_hit;
    logic [31:0] w_lookup_data;

    // Walk oldest to youngest so the youngest match overrides
    always_comb begin
        w_lookup_hit  = 1'b0;
        w_lookup_data = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if ((PTR_W'(k) < w_count) &&
                (r_addr[IDX_W'(r_rptr + PTR_W'(k))] == iLOOKUP_ADDR)) begin
                w_lookup_hit  = 1'b1;
                w_lookup_data = r_data[IDX_W'(r_rptr + PTR_W'(k))];
            end
        end
    end

    assign oLOOKUP_HIT  = w_lookup_hit;
    assign oLOOKUP_DATA = w_lookup_data;
`endif

    assign oWR_BUSY           = w_full;
    assign oEMPTY             = w_empty;
    assign oCOUNT             = w_count;
    assign oREGIST_DATA_VALID = r_strobe;
    assign oREGIST_DATA       = r_regist_data;

endmodule

// File: tb/tb_allocate_sysreg_commit_buffer.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for allocate_sysreg_commit_buffer (DEPTH=4, NUM_REG=8).
// Stimulus pushes expected strobes into a queue; a negedge monitor pops and
// compares whenever a strobe appears. Status outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_allocate_sysreg_commit_buffer;

    logic        iCLOCK = 1'b0;
    logic        iRESET = 1'b1;
    logic        iRESET_SYNC = 1'b0;
    logic        iWR_VALID = 1'b0;
    logic [4:0]  iWR_ADDR = '0;
    logic [31:0] iWR_DATA = '0;
    logic        oWR_BUSY;
    logic        iCOMMIT_VALID = 1'b0;
    logic        iFLUSH = 1'b0;
    logic [7:0]  oREGIST_DATA_VALID;
    logic [31:0] oREGIST_DATA;
    logic        oEMPTY;
    logic [2:0]  oCOUNT;
`ifdef ALLOCATE_SYSREG_FORWARD_EN
    logic [4:0]  iLOOKUP_ADDR = '0;
    logic        oLOOKUP_HIT;
    logic [31:0] oLOOKUP_DATA;
`endif

    allocate_sysreg_commit_buffer #(.DEPTH(4), .NUM_REG(8), .ADDR_W(5)) dut (
        .iCLOCK             (iCLOCK),
        .iRESET             (iRESET),
        .iRESET_SYNC        (iRESET_SYNC),
        .iWR_VALID          (iWR_VALID),
        .iWR_ADDR           (iWR_ADDR),
        .iWR_DATA           (iWR_DATA),
        .oWR_BUSY           (oWR_BUSY),
        .iCOMMIT_VALID      (iCOMMIT_VALID),
        .iFLUSH             (iFLUSH),
        .oREGIST_DATA_VALID (oREGIST_DATA_VALID),
        .oREGIST_DATA       (oREGIST_DATA),
        .oEMPTY             (oEMPTY),
`ifdef ALLOCATE_SYSREG_FORWARD_EN
        .iLOOKUP_ADDR       (iLOOKUP_ADDR),
        .oLOOKUP_HIT        (oLOOKUP_HIT),
        .oLOOKUP_DATA       (oLOOKUP_DATA),
`endif
        .oCOUNT             (oCOUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [7:0]  strobe;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One clock with the given inputs; outputs are observed #1 after the edge
    task automatic step(input logic wv, input logic [4:0] a, input logic [31:0] d,
                        input logic cm, input logic fl, input logic rs);
        iWR_VALID     = wv;
        iWR_ADDR      = a;
        iWR_DATA      = d;
        iCOMMIT_VALID = cm;
        iFLUSH        = fl;
        iRESET_SYNC   = rs;
        @(posedge iCLOCK);
        #1;
        iWR_VALID     = 1'b0;
        iCOMMIT_VALID = 1'b0;
        iFLUSH        = 1'b0;
        iRESET_SYNC   = 1'b0;
    endtask

    task automatic enq(input logic [4:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic commit_exp(input logic [7:0] s, input logic [31:0] d);
        exp_t e;
        e.strobe = s;
        e.data   = d;
        exp_q.push_back(e);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Every strobe must match the oldest outstanding expectation
    always @(negedge iCLOCK) begin
        if (!iRESET && oREGIST_DATA_VALID != '0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got 0x%02h data 0x%08h expected none at %0t",
                         oREGIST_DATA_VALID, oREGIST_DATA, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe", 32'(oREGIST_DATA_VALID), 32'(e.strobe));
                chk("strobe_data", oREGIST_DATA, e.data);
            end
        end
    end

    task automatic drain_check(input string name);
        idle();
        idle();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge iCLOCK);
        #1 iRESET = 1'b0;
        chk("rst_empty", 32'(oEMPTY), 32'd1);
        chk("rst_count", 32'(oCOUNT), 32'd0);
        chk("rst_busy", 32'(oWR_BUSY), 32'd0);
        chk("rst_strobe", 32'(oREGIST_DATA_VALID), 32'd0);
        chk("rst_data", oREGIST_DATA, 32'd0);

        // Single write and commit
        enq(5'd2, 32'h1234_5678);
        chk("t1_count", 32'(oCOUNT), 32'd1);
        commit_exp(8'h04, 32'h1234_5678);
        chk("t1_empty", 32'(oEMPTY), 32'd1);
        drain_check("t1_pending");

        // Fill, then enqueue while full with a simultaneous commit
        for (int i = 0; i < 4; i++) enq(5'(i), 32'h10 + 32'(i));
        chk("t2_busy", 32'(oWR_BUSY), 32'd1);
        chk("t2_count4", 32'(oCOUNT), 32'd4);
        exp_q.push_back('{strobe: 8'h01, data: 32'h10});
        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        chk("t2_count3", 32'(oCOUNT), 32'd3);
        chk("t2_notbusy", 32'(oWR_BUSY), 32'd0);
        commit_exp(8'h02, 32'h11);
        commit_exp(8'h04, 32'h12);
        commit_exp(8'h08, 32'h13);
        chk("t2_empty", 32'(oEMPTY), 32'd1);
        drain_check("t2_pending");

        // Same register twice retires in order
        enq(5'd1, 32'hA);
        enq(5'd1, 32'hB);
        commit_exp(8'h02, 32'hA);
        commit_exp(8'h02, 32'hB);
        drain_check("t3_pending");

        // Commit and flush together
        enq(5'd4, 32'h44);
        enq(5'd5, 32'h55);
        enq(5'd6, 32'h66);
        exp_q.push_back('{strobe: 8'h10, data: 32'h44});
        step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
        chk("t4_empty", 32'(oEMPTY), 32'd1);
        chk("t4_count", 32'(oCOUNT), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t4_hold_data", oREGIST_DATA, 32'h44);
        drain_check("t4_pending");

        // Enqueue during flush is dropped
        enq(5'd3, 32'h33);
        step(1'b1, 5'd2, 32'h22, 1'b0, 1'b1, 1'b0);
        chk("t5_flush_enq_count", 32'(oCOUNT), 32'd0);

        // Out-of-range register index pops silently
        enq(5'd9, 32'h99);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_oor_strobe", 32'(oREGIST_DATA_VALID), 32'd0);
        chk("t6_oor_data", oREGIST_DATA, 32'h44);
        chk("t6_oor_empty", 32'(oEMPTY), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("t6_empty_commit_count", 32'(oCOUNT), 32'd0);
        drain_check("t6_pending");

        // Simultaneous push and pop
        enq(5'd7, 32'h77);
        exp_q.push_back('{strobe: 8'h80, data: 32'h77});
        step(1'b1, 5'd0, 32'h700, 1'b1, 1'b0, 1'b0);
        chk("t7_count", 32'(oCOUNT), 32'd1);
        commit_exp(8'h01, 32'h700);
        drain_check("t7_pending");

        // Async reset mid-cycle with a strobe in flight and entries pending
        enq(5'd2, 32'hC0);
        enq(5'd3, 32'hC1);
        enq(5'd4, 32'hC2);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #1 iRESET = 1'b1;
        #1;
        chk("t8_async_empty", 32'(oEMPTY), 32'd1);
        chk("t8_async_count", 32'(oCOUNT), 32'd0);
        chk("t8_async_strobe", 32'(oREGIST_DATA_VALID), 32'd0);
        chk("t8_async_data", oREGIST_DATA, 32'd0);
        @(negedge iCLOCK);
        iRESET = 1'b0;

        // Synchronous reset wins over a same-cycle commit
        enq(5'd5, 32'h5A);
        commit_exp(8'h20, 32'h5A);
        enq(5'd1, 32'hD0);
        enq(5'd2, 32'hD1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        chk("t9_sync_empty", 32'(oEMPTY), 32'd1);
        chk("t9_sync_count", 32'(oCOUNT), 32'd0);
        chk("t9_sync_strobe", 32'(oREGIST_DATA_VALID), 32'd0);
        chk("t9_sync_data", oREGIST_DATA, 32'd0);
        drain_check("t9_pending");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
